// File: rtl/agc_pkg.sv
// Shared fixed-point helpers for the IQ AGC datapath: defaults, derived widths,
// rounding, symmetric saturation and clamping on a common wide signed type.
package agc_pkg;

  localparam int unsigned DEF_W_IN      = 16;
  localparam int unsigned DEF_W_OUT     = 16;
  localparam int unsigned DEF_W_GAIN    = 16;
  localparam int unsigned DEF_F_GAIN    = 8;
  localparam int unsigned DEF_W_COEF    = 16;
  localparam int unsigned DEF_F_COEF    = 14;
  localparam int unsigned DEF_GAIN_INIT = 256;
  localparam int unsigned DEF_GAIN_MIN  = 1;
  localparam int unsigned DEF_GAIN_MAX  = 65535;

  localparam int unsigned W_WIDE = 64;
  typedef logic signed [W_WIDE-1:0] wide_t;

  // Signed sample times zero-extended unsigned gain.
  function automatic int unsigned prod_width(input int unsigned w_in, input int unsigned w_gain);
    return w_in + w_gain + 1;
  endfunction

  // Round half up, then arithmetic shift right.
  function automatic wide_t round_shift(input wide_t x, input int unsigned sh);
    wide_t bias;
    bias = (sh == 0) ? '0 : (wide_t'(1) <<< (sh - 1));
    return (x + bias) >>> sh;
  endfunction

  function automatic wide_t sat_symmetric(input wide_t x, input int unsigned w);
    wide_t lim;
    lim = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    if (x > lim)  return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/agc_loop_iq_if.sv
// Complex sample stream: signed I/Q pair qualified by a valid strobe.
interface agc_loop_iq_if #(
  parameter int unsigned W = 16
);
  logic signed [W-1:0] dataI;
  logic signed [W-1:0] dataQ;
  logic                valid;

  modport master (output dataI, dataQ, valid);
  modport slave  (input  dataI, dataQ, valid);
endinterface

// File: rtl/agc_env_ema.sv
// Envelope detector: |I|+|Q| smoothed by a first-order EMA, updated per valid sample.
module agc_env_ema
  import agc_pkg::*;
#(
  parameter int unsigned W_OUT  = DEF_W_OUT,
  parameter int unsigned W_COEF = DEF_W_COEF,
  parameter int unsigned F_COEF = DEF_F_COEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic signed [W_OUT-1:0] dataI_i,
  input  logic signed [W_OUT-1:0] dataQ_i,
  input  logic [W_COEF-1:0]       a_i,
  output logic [W_OUT:0]          env_o,
  output logic                    valid_o
);

  localparam int unsigned W_ENV = W_OUT + 1;

  logic [W_ENV-1:0] env_q, env_d;
  logic             valid_q;
  wide_t            abs_i, abs_q, diff, upd;

  always_comb begin
    abs_i = wide_t'(dataI_i);
    if (abs_i < 0) abs_i = -abs_i;
    abs_q = wide_t'(dataQ_i);
    if (abs_q < 0) abs_q = -abs_q;
    diff  = abs_i + abs_q - wide_t'(env_q);
    upd   = wide_t'(env_q) + ((wide_t'(a_i) * diff) >>> F_COEF);
    env_d = env_q;
    if (valid_i) env_d = W_ENV'(clamp(upd, '0, (wide_t'(1) <<< W_ENV) - wide_t'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      env_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      env_q   <= env_d;
      valid_q <= valid_i;
    end
  end

  assign env_o   = env_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/agc_loop_iq.sv
// Closed-loop IQ AGC: gain multiply, round/saturate, envelope EMA, gain update.
module agc_loop_iq
  import agc_pkg::*;
#(
  parameter int unsigned W_IN      = DEF_W_IN,
  parameter int unsigned W_OUT     = DEF_W_OUT,
  parameter int unsigned W_GAIN    = DEF_W_GAIN,
  parameter int unsigned F_GAIN    = DEF_F_GAIN,
  parameter int unsigned W_COEF    = DEF_W_COEF,
  parameter int unsigned F_COEF    = DEF_F_COEF,
  parameter int unsigned GAIN_INIT = DEF_GAIN_INIT,
  parameter int unsigned GAIN_MIN  = DEF_GAIN_MIN,
  parameter int unsigned GAIN_MAX  = DEF_GAIN_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W_COEF-1:0]   i_alpha,
  input  logic [W_COEF-1:0]   i_a,
  input  logic [W_OUT:0]      i_reference,
  input  logic                i_freeze,
  agc_loop_iq_if.slave        s_chans,
  agc_loop_iq_if.master       m_chans,
  output logic                m_sat,
  output logic [W_GAIN-1:0]   o_gain,
  output logic [W_OUT:0]      o_env
);

  localparam int unsigned W_P = prod_width(W_IN, W_GAIN);

  logic [W_GAIN-1:0]       gain_q, gain_d;
  logic signed [W_P-1:0]   pI_q, pQ_q, pI_d, pQ_d;
  logic                    pvld_q;
  logic signed [W_OUT-1:0] m_dataI_q, m_dataQ_q, m_dataI_d, m_dataQ_d;
  logic                    m_valid_q, m_sat_q, m_sat_d;
  logic [W_OUT:0]          env;
  logic                    env_vld;
  wide_t                   rI, rQ, sI, sQ, gain_w;

  // Stage A: product with the gain register value at the capturing edge
  always_comb begin
    pI_d = W_P'($signed(s_chans.dataI)) * W_P'($signed({1'b0, gain_q}));
    pQ_d = W_P'($signed(s_chans.dataQ)) * W_P'($signed({1'b0, gain_q}));
  end

  // Stage B: round, saturate, flag clipping
  always_comb begin
    rI        = round_shift(wide_t'(pI_q), F_GAIN);
    rQ        = round_shift(wide_t'(pQ_q), F_GAIN);
    sI        = sat_symmetric(rI, W_OUT);
    sQ        = sat_symmetric(rQ, W_OUT);
    m_dataI_d = W_OUT'(sI);
    m_dataQ_d = W_OUT'(sQ);
    m_sat_d   = (sI != rI) || (sQ != rQ);
  end

  // Stage D: gain update from envelope error; wide arithmetic so clamping never wraps
  always_comb begin
    gain_w = clamp(wide_t'(gain_q)
                   + ((wide_t'(i_alpha) * (wide_t'(i_reference) - wide_t'(env))) >>> F_COEF),
                   wide_t'(GAIN_MIN), wide_t'(GAIN_MAX));
    gain_d = gain_q;
    if (env_vld && !i_freeze) gain_d = W_GAIN'(gain_w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gain_q    <= W_GAIN'(GAIN_INIT);
      pI_q      <= '0;
      pQ_q      <= '0;
      pvld_q    <= 1'b0;
      m_dataI_q <= '0;
      m_dataQ_q <= '0;
      m_valid_q <= 1'b0;
      m_sat_q   <= 1'b0;
    end else begin
      gain_q    <= gain_d;
      pvld_q    <= s_chans.valid;
      m_valid_q <= pvld_q;
      if (s_chans.valid) begin
        pI_q <= pI_d;
        pQ_q <= pQ_d;
      end
      if (pvld_q) begin
        m_dataI_q <= m_dataI_d;
        m_dataQ_q <= m_dataQ_d;
        m_sat_q   <= m_sat_d;
      end
    end
  end

  agc_env_ema #(
    .W_OUT  (W_OUT),
    .W_COEF (W_COEF),
    .F_COEF (F_COEF)
  ) u_env (
    .clk     (clk),
    .reset   (reset),
    .valid_i (m_valid_q),
    .dataI_i (m_dataI_q),
    .dataQ_i (m_dataQ_q),
    .a_i     (i_a),
    .env_o   (env),
    .valid_o (env_vld)
  );

  assign m_chans.dataI = m_dataI_q;
  assign m_chans.dataQ = m_dataQ_q;
  assign m_chans.valid = m_valid_q;
  assign m_sat         = m_sat_q;
  assign o_gain        = gain_q;
  assign o_env         = env;

endmodule

// File: tb/tb_agc_loop_iq.sv
// Scoreboard bench for agc_loop_iq: stimulus queues expectations, a negedge monitor compares.
module tb_agc_loop_iq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_alpha = '0;
  logic [15:0] i_a = '0;
  logic [16:0] i_reference = '0;
  logic        i_freeze = 1'b0;
  logic        m_sat;
  logic [15:0] o_gain;
  logic [16:0] o_env;

  always #5 clk = ~clk;

  agc_loop_iq_if #(.W(16)) s_if ();
  agc_loop_iq_if #(.W(16)) m_if ();

  agc_loop_iq #(
    .W_IN(16), .W_OUT(16), .W_GAIN(16), .F_GAIN(8), .W_COEF(16), .F_COEF(14),
    .GAIN_INIT(256), .GAIN_MIN(1), .GAIN_MAX(65535)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_alpha     (i_alpha),
    .i_a         (i_a),
    .i_reference (i_reference),
    .i_freeze    (i_freeze),
    .s_chans     (s_if),
    .m_chans     (m_if),
    .m_sat       (m_sat),
    .o_gain      (o_gain),
    .o_env       (o_env)
  );

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               sat;
  } exp_t;

  typedef struct {
    string  name;
    longint act;
    longint exp;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  exp_t e;
  chk_t c;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_vec++;
      if (c.act != c.exp) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
      end
    end
    if (m_if.valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got I=%0d Q=%0d sat=%0b expected no output",
                 m_if.dataI, m_if.dataQ, m_sat);
      end else begin
        e = exp_q.pop_front();
        if (m_if.dataI !== e.i || m_if.dataQ !== e.q || m_sat !== e.sat) begin
          n_err++;
          $display("FAIL sample: got I=%0d Q=%0d sat=%0b expected I=%0d Q=%0d sat=%0b",
                   m_if.dataI, m_if.dataQ, m_sat, e.i, e.q, e.sat);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_q.push_back('{nm, act, exp});
  endtask

  task automatic send(input int vi, input int vq, input int ei, input int eq, input bit es);
    s_if.dataI = 16'(vi);
    s_if.dataQ = 16'(vq);
    s_if.valid = 1'b1;
    exp_q.push_back('{16'(ei), 16'(eq), es});
    cyc();
    s_if.valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      cyc();
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    cyc(3);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_if.dataI = '0;
    s_if.dataQ = '0;
    s_if.valid = 1'b0;

    // Reset state
    cyc(3);
    chk("reset_gain", o_gain, 256);
    chk("reset_env", o_env, 0);
    chk("reset_valid", m_if.valid, 0);
    chk("reset_dataI", m_if.dataI, 0);
    chk("reset_dataQ", m_if.dataQ, 0);
    chk("reset_sat", m_sat, 0);
    reset = 1'b0;

    // Unity gain pass-through
    send(1000, -500, 1000, -500, 0);
    send(3, -3, 3, -3, 0);
    drain();
    chk("unity_gain", o_gain, 256);

    // Lock: envelope reaches reference after the first sample
    pulse_reset();
    i_a = 16'd16384; i_alpha = 16'd16384; i_reference = 17'd4000;
    send(4000, 0, 4000, 0, 0);
    cyc(2);
    chk("lock_env_first", o_env, 4000);
    for (int n = 0; n < 4; n++) send(4000, 0, 4000, 0, 0);
    drain();
    chk("lock_gain", o_gain, 256);
    chk("lock_env", o_env, 4000);

    // Clamp: zero input, gain climbs by 1000 per sample up to GAIN_MAX
    pulse_reset();
    i_reference = 17'd1000;
    for (int n = 0; n < 65; n++) send(0, 0, 0, 0, 0);
    drain();
    chk("clamp_gain_65", o_gain, 65256);
    send(0, 0, 0, 0, 0);
    drain();
    chk("clamp_gain_66", o_gain, 65535);
    for (int n = 0; n < 3; n++) send(0, 0, 0, 0, 0);
    drain();
    chk("clamp_gain_hold", o_gain, 65535);
    chk("clamp_env", o_env, 0);

    // Saturation and rounding at gain 65535
    i_alpha = '0;
    send(200, 0, 32767, 0, 1);
    send(-200, 0, -32767, 0, 1);
    send(1, -1, 256, -256, 0);
    send(100, -100, 25600, -25600, 0);
    send(0, 200, 0, 32767, 1);
    drain();
    chk("sat_gain_held", o_gain, 65535);

    // Freeze: envelope tracks, gain held despite error
    pulse_reset();
    i_freeze = 1'b1; i_alpha = 16'd16384; i_a = 16'd16384; i_reference = 17'd1000;
    for (int n = 0; n < 4; n++) send(2000, 0, 2000, 0, 0);
    drain();
    chk("freeze_gain", o_gain, 256);
    chk("freeze_env", o_env, 2000);

    // Reset mid-burst: the sample still in flight is dropped
    i_freeze = 1'b0;
    send(2000, 0, 2000, 0, 0);
    send(2000, 0, 2000, 0, 0);
    send(2000, 0, 2000, 0, 0);
    reset = 1'b1;
    cyc();
    exp_q.delete();
    chk("midrst_valid", m_if.valid, 0);
    chk("midrst_gain", o_gain, 256);
    chk("midrst_env", o_env, 0);
    reset = 1'b0;
    i_alpha = '0;
    cyc(3);
    send(1000, -500, 1000, -500, 0);
    drain();
    chk("post_reset_gain", o_gain, 256);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
